franken_mem_arbiter: RTL and testbench

- Shares one single-port memory between two requesters: the instruction-fetch port (I) and the load/store port (D) of the franken_riscv core.
- Sits between the core and the unified memory and lets the core run with a single RAM port.
- Registers each transaction and arbitrates round-robin on ties.
- Holds the memory request until the memory acknowledges it or a timeout expires.
- Returns read data and a one-cycle ack pulse to the granted requester.

---
 rtl/franken_mem_arbiter_if.sv | 49 ++++
 rtl/franken_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_franken_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/franken_mem_arbiter_if.sv
// Core-side (I and D requesters) and memory-side signals of the franken_mem_arbiter.
// The master view belongs to the arbiter. The slave view belongs to the core and memory environment.
interface franken_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_addr, d_we, d_be, d_wdata,
        input  mem_ack, mem_rdata,
        output i_ack, i_rdata, i_err,
        output d_ack, d_rdata, d_err,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_addr, d_we, d_be, d_wdata,
        output mem_ack, mem_rdata,
        input  i_ack, i_rdata, i_err,
        input  d_ack, d_rdata, d_err,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/franken_mem_arbiter.sv
// Shares one single-port memory between the I (fetch) and D (load/store) ports.
// It registers each transaction, breaks ties round-robin, and aborts a transaction on timeout.
module franken_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  reset,
    franken_mem_arbiter_if.master bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t            r_state;
    logic              r_grant_d;
    logic              r_last_d;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [BE_W-1:0]   r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              r_i_ack;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_i_err;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_err;

    logic              w_pick_d;
    logic              w_timeout;

    // On a tie, grant the port that did not win last time.
    assign w_pick_d  = bus.d_req & (~bus.i_req | ~r_last_d);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every register, including the output flops, takes the async reset.
    //       mem_req must therefore fall the instant reset asserts, not at the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_grant_d   <= 1'b0;
            r_last_d    <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_i_err     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        r_grant_d <= w_pick_d;
                        r_mem_req <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_BUSY;
                        if (w_pick_d) begin
                            r_mem_addr  <= bus.d_addr;
                            r_mem_we    <= bus.d_we;
                            r_mem_be    <= bus.d_be;
                            r_mem_wdata <= bus.d_wdata;
                        end else begin
                            r_mem_addr  <= bus.i_addr;
                            r_mem_we    <= 1'b0;
                            r_mem_be    <= '1;
                            r_mem_wdata <= '0;
                        end
                    end
                end

                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_last_d  <= r_grant_d;
                        r_state   <= ST_RESP;
                        if (r_grant_d) begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= 1'b0;
                            r_d_rdata <= r_mem_we ? '0 : bus.mem_rdata;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_err   <= 1'b0;
                            r_i_rdata <= bus.mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_grant_d) begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_err   <= 1'b1;
                            r_i_rdata <= '0;
                        end
                    end
                end

                ST_RESP: begin
                    r_i_ack <= 1'b0;
                    r_i_err <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_d_err <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.i_err     = r_i_err;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_err     = r_d_err;
endmodule

// File: tb/tb_franken_mem_arbiter.sv
// Directed bench for franken_mem_arbiter.
// A small memory model acks after a programmable number of mem_req cycles and watches the protocol.
module tb_franken_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk;
    logic reset;

    franken_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    franken_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model control: ack in the mem_delay-th mem_req cycle (0 = never).
    int          mem_delay     = 1;
    logic [31:0] mem_rdata_val = '0;
    int          mem_req_run   = 0;
    int          mem_req_total = 0;

    // Protocol watchers
    int i_ack_cnt   = 0;
    int d_ack_cnt   = 0;
    int double_ack  = 0;
    int req_in_resp = 0;
    int unstable    = 0;

    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [3:0]    prev_be;
    logic [DW-1:0] prev_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Returns the number of ticks until the ack appears, or -1 when the budget runs out.
    task automatic wait_ack(input bit is_d, input int budget, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            tick();
            cycles++;
            seen = is_d ? bus.d_ack : bus.i_ack;
        end
        if (!seen) cycles = -1;
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.i_ack && bus.d_ack) double_ack++;
            if ((bus.i_ack || bus.d_ack) && bus.mem_req) req_in_resp++;
            if (bus.i_ack) i_ack_cnt++;
            if (bus.d_ack) d_ack_cnt++;
            if (bus.mem_req) begin
                if (mem_req_run > 0 && (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we ||
                                        bus.mem_be !== prev_be || bus.mem_wdata !== prev_wdata))
                    unstable++;
                prev_addr  = bus.mem_addr;
                prev_we    = bus.mem_we;
                prev_be    = bus.mem_be;
                prev_wdata = bus.mem_wdata;
                mem_req_run++;
                mem_req_total++;
                bus.mem_ack   = (mem_delay != 0) && (mem_req_run == mem_delay);
                bus.mem_rdata = mem_rdata_val;
            end else begin
                mem_req_run   = 0;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
            end
        end
    end

    initial begin
        int lat;
        int ia;
        int da;

        reset       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_addr  = '0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_wdata = '0;

        repeat (3) tick();
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_be", bus.mem_be, 0);
        check("rst_i_ack", bus.i_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        reset = 1'b1;
        tick();

        // Round-robin ties: D, then I, then D, then I.
        mem_delay     = 1;
        mem_rdata_val = 32'h1111_2222;
        bus.i_req  = 1'b1; bus.i_addr = 32'h10;
        bus.d_req  = 1'b1; bus.d_addr = 32'h20; bus.d_be = 4'hF;
        tick();
        check("tie1_req", bus.mem_req, 1);
        check("tie1_grant_d", bus.mem_addr, 32'h20);
        wait_ack(1'b1, 5, lat);
        check("tie1_lat", lat, 1);
        check("tie1_d_rdata", bus.d_rdata, 32'h1111_2222);
        bus.d_addr = 32'h24;
        tick();
        check("tie_idle_gap", bus.mem_req, 0);
        tick();
        check("tie2_grant_i", bus.mem_addr, 32'h10);
        wait_ack(1'b0, 5, lat);
        check("tie2_lat", lat, 1);
        bus.i_addr = 32'h14;
        tick();
        tick();
        check("tie3_grant_d", bus.mem_addr, 32'h24);
        wait_ack(1'b1, 5, lat);
        check("tie3_lat", lat, 1);
        bus.d_req = 1'b0;
        tick();
        tick();
        check("tie4_grant_i", bus.mem_addr, 32'h14);
        wait_ack(1'b0, 5, lat);
        check("tie4_lat", lat, 1);
        bus.i_req = 1'b0;
        check("tie_i_acks", i_ack_cnt, 2);
        check("tie_d_acks", d_ack_cnt, 2);
        tick();

        // Timeout of a D load: mem_req held for exactly TIMEOUT cycles.
        mem_delay     = 0;
        mem_req_total = 0;
        bus.d_req  = 1'b1; bus.d_addr = 32'h300; bus.d_we = 1'b0;
        wait_ack(1'b1, 10, lat);
        check("to_lat", lat, 5);
        check("to_d_err", bus.d_err, 1);
        check("to_d_rdata", bus.d_rdata, 0);
        check("to_mem_req_cycles", mem_req_total, 4);
        bus.d_req = 1'b0;
        tick();
        check("to_err_clear", bus.d_err, 0);
        check("to_ack_clear", bus.d_ack, 0);
        mem_delay     = 1;
        mem_rdata_val = 32'hCAFE_F00D;
        bus.d_req  = 1'b1; bus.d_addr = 32'h304;
        wait_ack(1'b1, 5, lat);
        check("to_next_lat", lat, 2);
        check("to_next_err", bus.d_err, 0);
        check("to_next_rdata", bus.d_rdata, 32'hCAFE_F00D);
        bus.d_req = 1'b0;
        tick();

        // Single fetch, memory acks in the second mem_req cycle.
        mem_delay     = 2;
        mem_rdata_val = 32'hDEAD_BEEF;
        mem_req_total = 0;
        bus.i_req  = 1'b1; bus.i_addr = 32'h100;
        tick();
        check("f_mem_req", bus.mem_req, 1);
        check("f_mem_addr", bus.mem_addr, 32'h100);
        check("f_mem_we", bus.mem_we, 0);
        check("f_mem_be", bus.mem_be, 4'hF);
        check("f_mem_wdata", bus.mem_wdata, 0);
        wait_ack(1'b0, 10, lat);
        check("f_lat", lat, 2);
        check("f_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        check("f_i_err", bus.i_err, 0);
        check("f_mem_req_cycles", mem_req_total, 2);
        bus.i_req = 1'b0;
        tick();
        check("f_ack_one_cycle", bus.i_ack, 0);

        // Byte store, memory acks in the third mem_req cycle.
        mem_delay     = 3;
        mem_rdata_val = 32'h5555_AAAA;
        mem_req_total = 0;
        unstable      = 0;
        bus.d_req  = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h203;
        bus.d_be   = 4'b1000; bus.d_wdata = 32'hAB00_0000;
        tick();
        check("s_mem_addr", bus.mem_addr, 32'h203);
        check("s_mem_we", bus.mem_we, 1);
        check("s_mem_be", bus.mem_be, 4'b1000);
        check("s_mem_wdata", bus.mem_wdata, 32'hAB00_0000);
        wait_ack(1'b1, 10, lat);
        check("s_lat", lat, 3);
        check("s_d_rdata", bus.d_rdata, 0);
        check("s_d_err", bus.d_err, 0);
        check("s_mem_req_cycles", mem_req_total, 3);
        check("s_stable", unstable, 0);
        check("s_i_rdata_held", bus.i_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'hF;
        tick();

        // Back-to-back fetches with a same-cycle memory ack.
        mem_delay     = 1;
        mem_rdata_val = 32'hA0;
        req_in_resp   = 0;
        bus.i_req  = 1'b1; bus.i_addr = 32'h400;
        wait_ack(1'b0, 10, lat);
        check("b2b_1_lat", lat, 2);
        check("b2b_1_rdata", bus.i_rdata, 32'hA0);
        mem_rdata_val = 32'hA1; bus.i_addr = 32'h404;
        wait_ack(1'b0, 10, lat);
        check("b2b_2_lat", lat, 3);
        check("b2b_2_rdata", bus.i_rdata, 32'hA1);
        mem_rdata_val = 32'hA2; bus.i_addr = 32'h408;
        wait_ack(1'b0, 10, lat);
        check("b2b_3_lat", lat, 3);
        check("b2b_3_rdata", bus.i_rdata, 32'hA2);
        bus.i_req = 1'b0;
        tick();
        check("b2b_no_req_in_resp", req_in_resp, 0);

        // Reset while BUSY: mem_req falls without a clock edge and no ack is pulsed.
        mem_delay = 0;
        ia = i_ack_cnt;
        da = d_ack_cnt;
        bus.i_req  = 1'b1; bus.i_addr = 32'h500;
        tick();
        check("rb_mem_req_before", bus.mem_req, 1);
        reset = 1'b0;
        #1;
        check("rb_mem_req_async", bus.mem_req, 0);
        check("rb_i_ack", bus.i_ack, 0);
        bus.d_req  = 1'b1; bus.d_addr = 32'h600;
        repeat (2) tick();
        mem_delay = 1;
        reset = 1'b1;
        tick();
        check("rb_grant_d", bus.mem_addr, 32'h600);
        wait_ack(1'b1, 5, lat);
        check("rb_d_lat", lat, 1);
        bus.d_req = 1'b0;
        tick();
        tick();
        check("rb_grant_i", bus.mem_addr, 32'h500);
        wait_ack(1'b0, 5, lat);
        check("rb_i_lat", lat, 1);
        bus.i_req = 1'b0;
        check("rb_i_acks", i_ack_cnt, ia + 1);
        check("rb_d_acks", d_ack_cnt, da + 1);
        tick();

        check("no_double_ack", double_ack, 0);
        check("fields_stable", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
